intersection_monitor: RTL and testbench
=======================================

INTERSECTION_MONITOR -- requirements
Module: intersection_monitor

Interface
REQ-001 SHALL have parameter MIN_YELLOW, default 3, the minimum legal number of consecutive yellow samples per car head.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the phase counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports n_car, s_car, e_car, w_car  input  2 each  car heads; 00 red, 01 yellow, 10 green, 11 invalid.
REQ-006 SHALL have ports n_ped, s_ped, e_ped, w_ped  input  2 each  pedestrian heads; same encoding.
REQ-007 SHALL have port fault_clr  input  1  clears the sticky fault.
REQ-008 SHALL have port fault  output  1  sticky fault flag.
REQ-009 SHALL have port fault_code  output  3  code of the first fault since the last clear.
REQ-010 SHALL have port fault_src  output  2  approach of the first fault; 0 N, 1 S, 2 E, 3 W.
REQ-011 SHALL have port phase_cnt  output  CNT_W  count of N/S green-phase starts.

Function
REQ-012 SHALL sample all eight heads on every rising clk; each sample is one evaluation.
REQ-013 SHALL hold a previous-state register per car head; its reset value is red.
REQ-014 SHALL flag code 1 (cross conflict) when any N/S car head is non-red while any E/W car head is non-red in the same sample.
REQ-015 SHALL flag code 2 (ped conflict) when an approach's ped head is green while that approach's car head is non-red.
REQ-016 SHALL flag code 3 (illegal sequence) on car transitions G->R, Y->G or R->Y.
- Legal transitions: R->R, R->G, G->G, G->Y, Y->Y, Y->R.
REQ-017 SHALL flag code 4 (invalid encoding) when any of the eight heads samples 11.
REQ-018 SHALL keep an 8-bit yellow-run counter per car head.
- Increments, saturating at 255, on each yellow sample.
- Cleared on each non-yellow sample.
REQ-019 SHALL flag code 5 (short yellow) on a Y->R transition whose yellow-run count is below MIN_YELLOW.
REQ-020 SHALL resolve simultaneous conditions by lowest code number.
- Within one code, the lowest approach index wins.
- fault_src is 0 for code 1.
REQ-021 SHALL latch fault, fault_code and fault_src on the same clk edge that samples the violating inputs.
- The outputs are visible in the following cycle, so detection latency is 1 clock.
REQ-022 SHALL hold the latched fault_code and fault_src while fault is 1 and ignore later violations.
REQ-023 SHALL clear fault, fault_code and fault_src when fault_clr is 1.
- If a violation is sampled in the same cycle, that violation is latched instead; a new fault wins over the clear.
REQ-024 SHALL increment phase_cnt by 1 when n_car or s_car transitions R->G and the previous N and S samples were both red.
- phase_cnt saturates at all-ones.
REQ-025 SHALL update the previous-state and yellow-run registers every cycle, including while fault is 1.

Reset
REQ-026 SHALL reset the following on rst=1 at a rising clk, with priority over all other inputs:
- fault=0, fault_code=0, fault_src=0, phase_cnt=0.
- All previous-state registers to red.
- All yellow-run counters to 0.
REQ-027 SHALL evaluate no violations in the reset cycle.
- The first sample after reset is checked against red history, so R->G is legal and a sampled Y is illegal (R->Y).

Verification
REQ-028 SHALL pass the normal cycle scenario:
- Stimulus: N/S green 10 cycles, yellow 3, all red 2, E/W green 10, yellow 3, red 2, peds green only while own car is red, repeated twice.
- Response: fault=0 throughout; phase_cnt=2.
REQ-029 SHALL pass the cross-conflict scenario:
- Stimulus: n_car=10 and e_car=10 in the same sample.
- Response: fault=1 the next cycle, fault_code=1, fault_src=0.
REQ-030 SHALL pass the illegal-sequence scenario:
- Stimulus: w_car goes 10 then 00 directly.
- Response: fault_code=3, fault_src=3.
- A later invalid sample on s_ped leaves fault_code=3.
REQ-031 SHALL pass the short-yellow scenario:
- Stimulus: e_car 10, then 01 for 2 cycles, then 00, with MIN_YELLOW=3.
- Response: fault_code=5, fault_src=2.
- Repeating with 3 yellow cycles gives fault=0.
REQ-032 SHALL pass the clear-versus-fault scenario:
- Stimulus: fault latched; fault_clr=1 in the same cycle as s_ped=11.
- Response: fault=1, fault_code=4, fault_src=1.
- fault_clr=1 with clean inputs gives fault=0, fault_code=0.
REQ-033 SHALL pass the reset mid-operation scenario:
- Stimulus: rst=1 for one cycle while n_car is yellow and fault=1.
- Response: all outputs 0 next cycle.
- If n_car is still 01 on the first post-reset sample, fault_code=3, fault_src=0.

Source files
------------

// File: rtl/intersection_monitor.sv
// Safety monitor for a four-way intersection: watches all car and pedestrian
// heads, latches the first conflict as a sticky fault and counts N/S phase starts.
module intersection_monitor #(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       n_car,
    input  logic [1:0]       s_car,
    input  logic [1:0]       e_car,
    input  logic [1:0]       w_car,
    input  logic [1:0]       n_ped,
    input  logic [1:0]       s_ped,
    input  logic [1:0]       e_ped,
    input  logic [1:0]       w_ped,
    input  logic             fault_clr,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_src,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] INV    = 2'b11;

    localparam int unsigned NUM_APP = 4;
    localparam int unsigned YEL_W   = 8;

    logic [1:0]       car      [NUM_APP];
    logic [1:0]       ped      [NUM_APP];
    logic [1:0]       prev_car [NUM_APP];
    logic [YEL_W-1:0] yel_cnt  [NUM_APP];

    logic               cross_v;
    logic [NUM_APP-1:0] ped_v;
    logic [NUM_APP-1:0] seq_v;
    logic [NUM_APP-1:0] inv_v;
    logic [NUM_APP-1:0] short_v;
    logic               viol;
    logic [2:0]         viol_code;
    logic [1:0]         viol_src;
    logic               ns_start;

    // Lowest approach index among the set bits.
    function automatic logic [1:0] first_idx(input logic [NUM_APP-1:0] v);
        if (v[0])      first_idx = 2'd0;
        else if (v[1]) first_idx = 2'd1;
        else if (v[2]) first_idx = 2'd2;
        else           first_idx = 2'd3;
    endfunction

    always_comb begin
        car[0] = n_car;
        car[1] = s_car;
        car[2] = e_car;
        car[3] = w_car;
        ped[0] = n_ped;
        ped[1] = s_ped;
        ped[2] = e_ped;
        ped[3] = w_ped;
    end

    // Per-approach violation conditions against the current sample and history.
    always_comb begin
        cross_v = ((car[0] != RED) || (car[1] != RED)) &&
                  ((car[2] != RED) || (car[3] != RED));
        ped_v   = '0;
        seq_v   = '0;
        inv_v   = '0;
        short_v = '0;
        for (int i = 0; i < NUM_APP; i++) begin
            ped_v[i]   = (ped[i] == GREEN) && (car[i] != RED);
            seq_v[i]   = ((prev_car[i] == GREEN)  && (car[i] == RED))   ||
                         ((prev_car[i] == YELLOW) && (car[i] == GREEN)) ||
                         ((prev_car[i] == RED)    && (car[i] == YELLOW));
            inv_v[i]   = (car[i] == INV) || (ped[i] == INV);
            short_v[i] = (prev_car[i] == YELLOW) && (car[i] == RED) &&
                         (32'(yel_cnt[i]) < MIN_YELLOW);
        end
    end

    // Lowest code wins, then lowest approach.
    always_comb begin
        viol      = 1'b1;
        viol_code = 3'd0;
        viol_src  = 2'd0;
        if (cross_v) begin
            viol_code = 3'd1;
        end else if (|ped_v) begin
            viol_code = 3'd2;
            viol_src  = first_idx(ped_v);
        end else if (|seq_v) begin
            viol_code = 3'd3;
            viol_src  = first_idx(seq_v);
        end else if (|inv_v) begin
            viol_code = 3'd4;
            viol_src  = first_idx(inv_v);
        end else if (|short_v) begin
            viol_code = 3'd5;
            viol_src  = first_idx(short_v);
        end else begin
            viol = 1'b0;
        end
    end

    assign ns_start = (prev_car[0] == RED) && (prev_car[1] == RED) &&
                      ((car[0] == GREEN) || (car[1] == GREEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_src  <= 2'd0;
            phase_cnt  <= '0;
            for (int i = 0; i < NUM_APP; i++) begin
                prev_car[i] <= RED;
                yel_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_APP; i++) begin
                prev_car[i] <= car[i];
                if (car[i] == YELLOW)
                    yel_cnt[i] <= (yel_cnt[i] != '1) ? yel_cnt[i] + YEL_W'(1) : yel_cnt[i];
                else
                    yel_cnt[i] <= '0;
            end

            if (ns_start && (phase_cnt != '1))
                phase_cnt <= phase_cnt + CNT_W'(1);

            // A fresh violation outranks a clear; a held fault ignores new ones.
            if (viol && (!fault || fault_clr)) begin
                fault      <= 1'b1;
                fault_code <= viol_code;
                fault_src  <= viol_src;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                fault_src  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_intersection_monitor.sv
// Directed-vector bench for intersection_monitor with hand-computed expectations.
module tb_intersection_monitor;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       n_car, s_car, e_car, w_car;
    logic [1:0]       n_ped, s_ped, e_ped, w_ped;
    logic             fault_clr;
    logic             fault;
    logic [2:0]       fault_code;
    logic [1:0]       fault_src;
    logic [CNT_W-1:0] phase_cnt;

    int checks = 0;
    int errors = 0;

    intersection_monitor #(.MIN_YELLOW(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .n_car      (n_car),
        .s_car      (s_car),
        .e_car      (e_car),
        .w_car      (w_car),
        .n_ped      (n_ped),
        .s_ped      (s_ped),
        .e_ped      (e_ped),
        .w_ped      (w_ped),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_src  (fault_src),
        .phase_cnt  (phase_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cars(input logic [1:0] n, input logic [1:0] s,
                            input logic [1:0] e, input logic [1:0] w);
        n_car = n; s_car = s; e_car = e; w_car = w;
    endtask

    task automatic set_peds(input logic [1:0] n, input logic [1:0] s,
                            input logic [1:0] e, input logic [1:0] w);
        n_ped = n; s_ped = s; e_ped = e; w_ped = w;
    endtask

    // Return all heads to red, let history settle, then clear the fault.
    task automatic settle_and_clear();
        set_cars(2'b00, 2'b00, 2'b00, 2'b00);
        set_peds(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic run_phase(input logic [1:0] ns, input logic [1:0] ew,
                             input logic [1:0] ns_ped, input logic [1:0] ew_ped,
                             input int cycles, inout logic seen);
        set_cars(ns, ns, ew, ew);
        set_peds(ns_ped, ns_ped, ew_ped, ew_ped);
        for (int c = 0; c < cycles; c++) begin
            tick();
            seen = seen | fault;
        end
    endtask

    logic seen_fault;

    initial begin
        rst       = 1'b1;
        fault_clr = 1'b0;
        set_cars(2'b00, 2'b00, 2'b00, 2'b00);
        set_peds(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_src", 32'(fault_src), 32'd0);
        check("rst_phase", 32'(phase_cnt), 32'd0);

        // Normal two-round cycle; peds green only while their own car is red.
        seen_fault = 1'b0;
        for (int r = 0; r < 2; r++) begin
            run_phase(2'b10, 2'b00, 2'b00, 2'b10, 10, seen_fault);
            if (r == 0) check("phase_after_first_start", 32'(phase_cnt), 32'd1);
            run_phase(2'b01, 2'b00, 2'b00, 2'b00, 3, seen_fault);
            run_phase(2'b00, 2'b00, 2'b00, 2'b00, 2, seen_fault);
            run_phase(2'b00, 2'b10, 2'b10, 2'b00, 10, seen_fault);
            run_phase(2'b00, 2'b01, 2'b00, 2'b00, 3, seen_fault);
            run_phase(2'b00, 2'b00, 2'b00, 2'b00, 2, seen_fault);
        end
        check("normal_no_fault", 32'(seen_fault), 32'd0);
        check("normal_phase_cnt", 32'(phase_cnt), 32'd2);

        // Cross conflict: N and E green together.
        set_cars(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        check("cross_fault", 32'(fault), 32'd1);
        check("cross_code", 32'(fault_code), 32'd1);
        check("cross_src", 32'(fault_src), 32'd0);
        check("cross_phase", 32'(phase_cnt), 32'd3);
        set_cars(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        check("held_code_ignores_gr", 32'(fault_code), 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_code", 32'(fault_code), 32'd0);

        // Illegal sequence on W: G straight to R.
        set_cars(2'b00, 2'b00, 2'b00, 2'b10);
        tick();
        check("w_green_legal", 32'(fault), 32'd0);
        set_cars(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        check("seq_fault", 32'(fault), 32'd1);
        check("seq_code", 32'(fault_code), 32'd3);
        check("seq_src", 32'(fault_src), 32'd3);
        s_ped = 2'b11;
        tick();
        check("seq_held_vs_invalid", 32'(fault_code), 32'd3);
        settle_and_clear();
        check("seq_cleared", 32'(fault), 32'd0);

        // Short yellow on E: two yellow samples.
        e_car = 2'b10; tick();
        e_car = 2'b01; tick();
        tick();
        e_car = 2'b00; tick();
        check("short_code", 32'(fault_code), 32'd5);
        check("short_src", 32'(fault_src), 32'd2);
        settle_and_clear();

        // Exactly MIN_YELLOW yellow samples is legal.
        e_car = 2'b10; tick();
        e_car = 2'b01; tick();
        tick();
        tick();
        e_car = 2'b00; tick();
        check("min_yellow_ok", 32'(fault), 32'd0);
        check("min_yellow_code", 32'(fault_code), 32'd0);

        // Code 2 beats code 4; within code 2 approach E is the only one.
        e_car = 2'b10; e_ped = 2'b10; w_ped = 2'b11;
        tick();
        check("prio_code", 32'(fault_code), 32'd2);
        check("prio_src", 32'(fault_src), 32'd2);
        settle_and_clear();

        // New fault wins over a clear in the same cycle.
        w_car = 2'b10; tick();
        w_car = 2'b00; tick();
        check("pre_clr_code", 32'(fault_code), 32'd3);
        s_ped = 2'b11; fault_clr = 1'b1;
        tick();
        check("clr_vs_fault_flag", 32'(fault), 32'd1);
        check("clr_vs_fault_code", 32'(fault_code), 32'd4);
        check("clr_vs_fault_src", 32'(fault_src), 32'd1);
        s_ped = 2'b00;
        tick();
        fault_clr = 1'b0;
        check("clean_clr_fault", 32'(fault), 32'd0);
        check("clean_clr_code", 32'(fault_code), 32'd0);
        check("clean_clr_src", 32'(fault_src), 32'd0);

        // Reset mid-operation with N yellow and a fault held.
        n_car = 2'b10; tick();
        n_car = 2'b01; w_ped = 2'b11;
        tick();
        check("pre_rst_fault", 32'(fault), 32'd1);
        check("pre_rst_code", 32'(fault_code), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_ped = 2'b00;
        check("mid_rst_fault", 32'(fault), 32'd0);
        check("mid_rst_code", 32'(fault_code), 32'd0);
        check("mid_rst_src", 32'(fault_src), 32'd0);
        check("mid_rst_phase", 32'(phase_cnt), 32'd0);
        tick();
        check("post_rst_ry_code", 32'(fault_code), 32'd3);
        check("post_rst_ry_src", 32'(fault_src), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
